// File: rtl/clkgen_phase_if.sv
// -----------------------------------------------------------------------------
// clkgen_phase_if
//
// Configuration write channel of clkgen_phase.
//
// Handshake: a write transfers on every rising clk edge where cfg_valid and
// cfg_ready are both high; cfg_sel/cfg_data must be stable while cfg_valid is
// high. cfg_valid may stay high across several cycles; each cycle with
// cfg_valid && cfg_ready is a separate write. cfg_err is a one-cycle pulse
// in the cycle after a handshake whose write was rejected.
//
// Signals:
//   cfg_valid  master -> slave  write request
//   cfg_ready  slave  -> master write can be accepted this cycle
//   cfg_sel    master -> slave  0 = divider, k = phase of channel k-1
//   cfg_data   master -> slave  divider (low CNT_W bits) or phase value
//   cfg_err    slave  -> master rejected-write pulse
// -----------------------------------------------------------------------------
interface clkgen_phase_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    localparam int SEL_W = $clog2(NUM_CH + 1);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_sel;
    logic [CNT_W:0]   cfg_data;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_sel,
        output cfg_data,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_sel,
        input  cfg_data,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clkgen_phase.sv
// -----------------------------------------------------------------------------
// clkgen_phase
//
// Fabric clock generator: NUM_CH registered clocks sharing one period
// P = 2*(div+1) input cycles, each shifted by its own phase (in input cycles).
// Reconfiguration is runt-free: an accepted write first lets every channel
// finish its current high pulse (DRAIN), then holds all outputs low for one
// full new period (MUTE) before the new settings run (RUN).
//
// Optional feature: define CLKGEN_GATE_EN to add the ch_en port and
// per-channel glitch-free gating. Without it every channel is always enabled.
//
// Ports:
//   clk        in   single clock domain
//   reset      in   synchronous, active-high
//   cfg        slave modport of clkgen_phase_if (valid/ready config writes)
//   ch_en      in   per-channel enable (CLKGEN_GATE_EN only)
//   clk_out    out  generated clocks, registered
//   locked     out  outputs stable for LOCK_PERIODS periods in RUN
//   fsm_state  out  current FSM state (0 MUTE, 1 RUN, 2 DRAIN), for debug
// -----------------------------------------------------------------------------
module clkgen_phase #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 8,
    parameter int RESET_DIV    = 0,
    parameter int LOCK_PERIODS = 4
) (
    input  logic              clk,
    input  logic              reset,
    clkgen_phase_if.slave     cfg,
`ifdef CLKGEN_GATE_EN
    input  logic [NUM_CH-1:0] ch_en,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked,
    output logic [1:0]        fsm_state
);
    localparam int SEL_W = $clog2(NUM_CH + 1);
    localparam int PW    = CNT_W + 1;     // epoch counter / phase width
    localparam int WW    = CNT_W + 3;     // headroom for ep + P
    localparam int LW    = (LOCK_PERIODS < 1) ? 1 : $clog2(LOCK_PERIODS + 1);

    localparam logic [1:0] ST_MUTE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(RESET_DIV);
    localparam logic [LW-1:0]    LOCK_TGT = LW'(LOCK_PERIODS);
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_CH);

    // Registered state
    logic [1:0]        state;
    logic [CNT_W-1:0]  div_q;
    logic [PW-1:0]     phase_q [NUM_CH];
    logic [PW-1:0]     ep_q;
    logic [NUM_CH-1:0] mask_q;
    logic [SEL_W-1:0]  pend_sel;
    logic [PW-1:0]     pend_data;
    logic [LW-1:0]     lock_cnt;
    logic              err_q;
    logic [NUM_CH-1:0] gate_q;

    // Next-state / decode signals
    logic [1:0]        state_n;
    logic [PW-1:0]     ep_n;
    logic [NUM_CH-1:0] mask_n;
    logic [NUM_CH-1:0] ungated;
    logic [NUM_CH-1:0] raw_nxt;
    logic              apply;
    logic [WW-1:0]     h_cur;
    logic [WW-1:0]     p_cur;
    logic [WW-1:0]     h_new;
    logic [WW-1:0]     p_new;
    logic [WW-1:0]     ep_w;
    logic              ep_last;
    logic              hs;
    logic              wr_bad;
    logic              wr_ok;

    // -------------------------------------------------------------------------
    // Period arithmetic for the held divider and for a pending divider write
    // -------------------------------------------------------------------------
    always_comb begin
        h_cur   = WW'(div_q) + WW'(1);
        p_cur   = h_cur << 1;
        h_new   = WW'(pend_data[CNT_W-1:0]) + WW'(1);
        p_new   = h_new << 1;
        ep_w    = WW'(ep_q);
        ep_last = (ep_w == p_cur - WW'(1));
    end

    // -------------------------------------------------------------------------
    // Per-channel waveform: high while the channel-local epoch
    // d = (ep + P - phase) mod P is in the first half of the period.
    // Both operands are < P, so one conditional subtract is enough.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [WW-1:0] d;
        d       = '0;
        ungated = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            d = ep_w + p_cur - WW'(phase_q[i]);
            if (d >= p_cur) begin
                d = d - p_cur;
            end
            ungated[i] = (d < h_cur);
        end
    end

    // -------------------------------------------------------------------------
    // Config write decode. A phase is checked against the period of the
    // divider currently held, not a pending one.
    // -------------------------------------------------------------------------
    assign hs = cfg.cfg_valid & cfg.cfg_ready;

    always_comb begin
        wr_bad = 1'b0;
        if (cfg.cfg_sel > SEL_MAX) begin
            wr_bad = 1'b1;
        end else if ((cfg.cfg_sel != '0) && (WW'(cfg.cfg_data) >= p_cur)) begin
            wr_bad = 1'b1;
        end
    end

    assign wr_ok = hs & ~wr_bad;

    // -------------------------------------------------------------------------
    // FSM: MUTE -> RUN -> DRAIN -> MUTE
    // ep doubles as the MUTE length counter, so MUTE lasts exactly P cycles
    // of the newly applied divider.
    // -------------------------------------------------------------------------
    always_comb begin
        state_n = state;
        ep_n    = ep_last ? '0 : ep_q + PW'(1);
        mask_n  = mask_q;
        raw_nxt = '0;
        apply   = 1'b0;
        case (state)
            ST_MUTE: begin
                if (ep_last) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                raw_nxt = ungated;
                if (wr_ok) begin
                    state_n = ST_DRAIN;
                    mask_n  = '0;
                end
            end
            ST_DRAIN: begin
                // A channel is masked from the first cycle its output is low,
                // so a pulse in flight always completes at full width.
                mask_n  = mask_q | ~clk_out;
                raw_nxt = ungated & ~mask_n;
                if (&mask_n) begin
                    state_n = ST_MUTE;
                    apply   = 1'b1;
                    ep_n    = '0;
                end
            end
            default: begin
                state_n = ST_MUTE;
                ep_n    = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Optional per-channel gating. The enable is only sampled while the
    // ungated value is low, so a pulse is either emitted whole or not at all.
    // -------------------------------------------------------------------------
`ifdef CLKGEN_GATE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!raw_nxt[i]) begin
                    gate_q[i] <= ch_en[i];
                end
            end
        end
    end
`else
    assign gate_q = '1;
`endif

    // -------------------------------------------------------------------------
    // Main register block
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_MUTE;
            div_q     <= DIV_RST;
            ep_q      <= '0;
            mask_q    <= '0;
            pend_sel  <= '0;
            pend_data <= '0;
            lock_cnt  <= '0;
            err_q     <= 1'b0;
            clk_out   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            state   <= state_n;
            ep_q    <= ep_n;
            mask_q  <= mask_n;
            clk_out <= raw_nxt & gate_q;
            err_q   <= hs & wr_bad;

            if (wr_ok) begin
                pend_sel  <= cfg.cfg_sel;
                pend_data <= cfg.cfg_data;
            end

            // Lock counts epoch wraps while RUN continues undisturbed.
            if ((state == ST_RUN) && !wr_ok) begin
                if (ep_last && (lock_cnt != LOCK_TGT)) begin
                    lock_cnt <= lock_cnt + LW'(1);
                end
            end else begin
                lock_cnt <= '0;
            end

            // Pending write is applied atomically on DRAIN -> MUTE. A new
            // divider clears every phase that no longer fits its period.
            if (apply) begin
                if (pend_sel == '0) begin
                    div_q <= pend_data[CNT_W-1:0];
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (WW'(phase_q[i]) >= p_new) begin
                            phase_q[i] <= '0;
                        end
                    end
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (pend_sel == SEL_W'(i + 1)) begin
                            phase_q[i] <= pend_data;
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cfg.cfg_ready = (state == ST_RUN);
    assign cfg.cfg_err   = err_q;
    assign locked        = (state == ST_RUN) && (lock_cnt == LOCK_TGT);
    assign fsm_state     = state;

endmodule
